// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory arbiter: FSM states, port indices
// and default bus widths.
package dmem_pkg;

    // Arbiter ownership states: free, held by the core, held by the loader.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_t;

    // Requester indices, also used as the round-robin pointer value.
    localparam logic PORT_CORE = 1'b0;
    localparam logic PORT_LOAD = 1'b1;

    localparam int DEF_ADDRESS_WIDTH = 32;
    localparam int DEF_DATA_WIDTH    = 32;

endpackage

// File: rtl/rr_pick2.sv
// Combinational 2-way round-robin picker. ptr names the port that wins
// when both request; a lone requester always wins.
module rr_pick2 (
    input  logic [1:0] req,
    input  logic       ptr,
    output logic [1:0] gnt
);

    // One-hot grant from the eligible requests and the tie-break pointer.
    always_comb begin
        gnt = 2'b00;
        if (req[0] && req[1]) begin
            gnt = ptr ? 2'b10 : 2'b01;
        end else if (req[0]) begin
            gnt = 2'b01;
        end else if (req[1]) begin
            gnt = 2'b10;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of a single-ported data memory with a 1-cycle
// registered read. Port 0 is the core load/store unit, port 1 the loader/DMA.
//
// Handshake: a beat transfers in any cycle where req_x && gnt_x. gnt_x is a
// combinational function of this cycle's requests and the ownership state,
// so a requester may present a new beat every cycle. A transferred read
// returns rvalid_x exactly one cycle later; rdata_x is 0 whenever rvalid_x
// is low. Writes return nothing.
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int ADDRESS_WIDTH = DEF_ADDRESS_WIDTH,
    parameter int DATA_WIDTH    = DEF_DATA_WIDTH
) (
    input  logic                     clk,
    input  logic                     rst_n,
    // port 0: core load/store unit
    input  logic                     req_0,
    input  logic                     lock_0,
    input  logic                     we_0,
    input  logic [ADDRESS_WIDTH-1:0] addr_0,
    input  logic [DATA_WIDTH-1:0]    wdata_0,
    output logic                     gnt_0,
    output logic                     rvalid_0,
    output logic [DATA_WIDTH-1:0]    rdata_0,
    // port 1: loader/DMA
    input  logic                     req_1,
    input  logic                     lock_1,
    input  logic                     we_1,
    input  logic [ADDRESS_WIDTH-1:0] addr_1,
    input  logic [DATA_WIDTH-1:0]    wdata_1,
    output logic                     gnt_1,
    output logic                     rvalid_1,
    output logic [DATA_WIDTH-1:0]    rdata_1,
    // memory side
    output logic                     mem_we,
    output logic [ADDRESS_WIDTH-1:0] mem_a,
    output logic [DATA_WIDTH-1:0]    mem_wd,
    input  logic [DATA_WIDTH-1:0]    mem_rd,
    // ownership state for observation
    output logic [1:0]               dbg_state
);

    state_t                   state;
    logic                     ptr;       // port that wins a tie in IDLE
    logic [1:0]               rd_pend;   // one-hot: read issued last cycle
    logic [ADDRESS_WIDTH-1:0] a_hold;
    logic [DATA_WIDTH-1:0]    wd_hold;

    logic [1:0]               elig;
    logic [1:0]               gnt;
    logic                     any_gnt;
    logic                     sel;
    logic                     g_we;
    logic                     g_lock;
    logic [ADDRESS_WIDTH-1:0] g_addr;
    logic [DATA_WIDTH-1:0]    g_wd;

    // Requests that may be granted: an owner shuts out the other port, and
    // nothing is granted while reset is held.
    always_comb begin
        elig = 2'b00;
        case (state)
            IDLE:    elig = {req_1, req_0};
            OWN0:    elig = {1'b0, req_0};
            OWN1:    elig = {req_1, 1'b0};
            default: elig = 2'b00;
        endcase
        if (!rst_n) begin
            elig = 2'b00;
        end
    end

    rr_pick2 u_pick (
        .req (elig),
        .ptr (ptr),
        .gnt (gnt)
    );

    assign any_gnt = |gnt;
    assign sel     = gnt[1];
    assign gnt_0   = gnt[0];
    assign gnt_1   = gnt[1];

    // Steer the granted port's beat onto the memory bus.
    always_comb begin
        g_we   = we_0;
        g_lock = lock_0;
        g_addr = addr_0;
        g_wd   = wdata_0;
        if (sel) begin
            g_we   = we_1;
            g_lock = lock_1;
            g_addr = addr_1;
            g_wd   = wdata_1;
        end
    end

    // Address and write data hold their last granted values when idle.
    assign mem_we = any_gnt & g_we;
    assign mem_a  = any_gnt ? g_addr : a_hold;
    assign mem_wd = any_gnt ? g_wd : wd_hold;

    // Ownership FSM and round-robin pointer. In OWNx the only way to see no
    // grant is req_x low, which also releases ownership.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            ptr   <= PORT_CORE;
        end else if (any_gnt) begin
            ptr <= ~sel;
            if (g_lock) begin
                state <= sel ? OWN1 : OWN0;
            end else begin
                state <= IDLE;
            end
        end else begin
            state <= IDLE;
        end
    end

    // Bus hold registers and the read tag that routes mem_rd back next cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_hold  <= '0;
            wd_hold <= '0;
            rd_pend <= 2'b00;
        end else begin
            if (any_gnt) begin
                a_hold  <= g_addr;
                wd_hold <= g_wd;
            end
            rd_pend <= (any_gnt && !g_we) ? gnt : 2'b00;
        end
    end

    assign rvalid_0  = rd_pend[0];
    assign rvalid_1  = rd_pend[1];
    assign rdata_0   = rd_pend[0] ? mem_rd : '0;
    assign rdata_1   = rd_pend[1] ? mem_rd : '0;
    assign dbg_state = state;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios plus a random phase, checked by
// a scoreboard fed from a transaction-level model of the arbitration rules.
module tb_dmem_arbiter;
  import dmem_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_0, lock_0, we_0, gnt_0, rvalid_0;
  logic [31:0] addr_0, wdata_0, rdata_0;
  logic        req_1, lock_1, we_1, gnt_1, rvalid_1;
  logic [31:0] addr_1, wdata_1, rdata_1;
  logic        mem_we;
  logic [31:0] mem_a, mem_wd, mem_rd;
  logic [1:0]  dbg_state;

  typedef struct packed {
    logic        req;
    logic        lock;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } port_in_t;

  typedef struct packed {
    logic        port;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] cyc;
  } gnt_rec_t;

  typedef struct packed {
    logic        port;
    logic [31:0] data;
    logic [31:0] cyc;
  } rd_rec_t;

  gnt_rec_t    exp_g_q[$];
  rd_rec_t     exp_r_q[$];
  gnt_rec_t    mon_g;
  rd_rec_t     mon_r;
  logic [31:0] stub_mem[256];
  logic [31:0] model_mem[256];
  int          owner;    // -1 none, else owning port
  int          prio;     // port that wins a tie
  logic [31:0] cyc = 32'd0;
  int          n_checks = 0;
  int          n_pass = 0;
  logic        mon_en = 1'b0;

  dmem_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .req_0(req_0), .lock_0(lock_0), .we_0(we_0), .addr_0(addr_0), .wdata_0(wdata_0),
    .gnt_0(gnt_0), .rvalid_0(rvalid_0), .rdata_0(rdata_0),
    .req_1(req_1), .lock_1(lock_1), .we_1(we_1), .addr_1(addr_1), .wdata_1(wdata_1),
    .gnt_1(gnt_1), .rvalid_1(rvalid_1), .rdata_1(rdata_1),
    .mem_we(mem_we), .mem_a(mem_a), .mem_wd(mem_wd), .mem_rd(mem_rd),
    .dbg_state(dbg_state)
  );

  // clock / cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 32'd1;

  // data memory stub: registered read, read-before-write
  always @(posedge clk) begin
    if (mem_we) stub_mem[mem_a[7:0]] <= mem_wd;
    mem_rd <= stub_mem[mem_a[7:0]];
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic port_in_t mk(input logic r, input logic l, input logic w,
                                  input logic [31:0] a, input logic [31:0] d);
    port_in_t p;
    p.req = r; p.lock = l; p.we = w; p.addr = a; p.wdata = d;
    return p;
  endfunction

  // drive one cycle of inputs and let the model predict the outcome
  task automatic apply(input port_in_t p0, input port_in_t p1);
    int       g;
    port_in_t pg;
    gnt_rec_t gr;
    rd_rec_t  rr;
    req_0 = p0.req; lock_0 = p0.lock; we_0 = p0.we; addr_0 = p0.addr; wdata_0 = p0.wdata;
    req_1 = p1.req; lock_1 = p1.lock; we_1 = p1.we; addr_1 = p1.addr; wdata_1 = p1.wdata;
    if (rst_n) begin
      g = -1;
      if (owner < 0) begin
        if (p0.req && p1.req) g = prio;
        else if (p0.req) g = 0;
        else if (p1.req) g = 1;
      end else if ((owner == 0) ? p0.req : p1.req) begin
        g = owner;
      end else begin
        owner = -1;
      end
      if (g >= 0) begin
        pg = (g == 1) ? p1 : p0;
        gr.port = (g == 1); gr.we = pg.we; gr.addr = pg.addr; gr.wdata = pg.wdata; gr.cyc = cyc;
        exp_g_q.push_back(gr);
        if (pg.we) begin
          model_mem[pg.addr[7:0]] = pg.wdata;
        end else begin
          rr.port = (g == 1); rr.data = model_mem[pg.addr[7:0]]; rr.cyc = cyc + 32'd1;
          exp_r_q.push_back(rr);
        end
        prio  = 1 - g;
        owner = pg.lock ? g : -1;
      end
    end
  endtask

  task automatic step(input port_in_t p0, input port_in_t p1);
    @(posedge clk);
    #1;
    apply(p0, p1);
  endtask

  task automatic expect_gnt(input string name, input logic e0, input logic e1);
    #2;
    chk({name, ".gnt_0"}, 64'(gnt_0), 64'(e0));
    chk({name, ".gnt_1"}, 64'(gnt_1), 64'(e1));
  endtask

  // scoreboard monitor: pops an expectation whenever the DUT shows a grant or rvalid
  always @(negedge clk) begin
    if (mon_en && rst_n) begin
      chk("gnt_onehot", 64'(gnt_0 & gnt_1), 64'd0);
      if (gnt_0 || gnt_1) begin
        if (exp_g_q.size() == 0) begin
          chk("gnt_unexpected", 64'(gnt_1), 64'(~gnt_1));
        end else begin
          mon_g = exp_g_q.pop_front();
          chk("gnt_port", 64'(gnt_1), 64'(mon_g.port));
          chk("gnt_cycle", 64'(cyc), 64'(mon_g.cyc));
          chk("mem_we", 64'(mem_we), 64'(mon_g.we));
          chk("mem_a", 64'(mem_a), 64'(mon_g.addr));
          chk("mem_wd", 64'(mem_wd), 64'(mon_g.wdata));
        end
      end else begin
        chk("mem_we_idle", 64'(mem_we), 64'd0);
      end
      if (rvalid_0 || rvalid_1) begin
        chk("rvalid_onehot", 64'(rvalid_0 & rvalid_1), 64'd0);
        if (exp_r_q.size() == 0) begin
          chk("rvalid_unexpected", 64'(rvalid_1), 64'(~rvalid_1));
        end else begin
          mon_r = exp_r_q.pop_front();
          chk("rvalid_port", 64'(rvalid_1), 64'(mon_r.port));
          chk("rvalid_cycle", 64'(cyc), 64'(mon_r.cyc));
          chk("rdata", 64'(rvalid_1 ? rdata_1 : rdata_0), 64'(mon_r.data));
        end
      end
      if (!rvalid_0) chk("rdata_0_zero", 64'(rdata_0), 64'd0);
      if (!rvalid_1) chk("rdata_1_zero", 64'(rdata_1), 64'd0);
    end
  end

  port_in_t none_p;
  port_in_t p0r, p1r;

  initial begin
    for (int i = 0; i < 256; i++) begin
      stub_mem[i]  = 32'hA5A5_0000 ^ (32'(i) * 32'h0101_0101);
      model_mem[i] = 32'hA5A5_0000 ^ (32'(i) * 32'h0101_0101);
    end
    stub_mem[8'h10]  = 32'hDEAD_BEEF;
    model_mem[8'h10] = 32'hDEAD_BEEF;
    owner  = -1;
    prio   = 0;
    none_p = mk(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);

    // reset held with both ports requesting: nothing may be granted
    apply(mk(1'b1, 1'b0, 1'b0, 32'h4, 32'h0), mk(1'b1, 1'b0, 1'b0, 32'h8, 32'h0));
    repeat (3) @(posedge clk);
    #3;
    chk("rst.gnt_0", 64'(gnt_0), 64'd0);
    chk("rst.gnt_1", 64'(gnt_1), 64'd0);
    chk("rst.rvalid_0", 64'(rvalid_0), 64'd0);
    chk("rst.mem_we", 64'(mem_we), 64'd0);
    chk("rst.mem_a", 64'(mem_a), 64'd0);
    chk("rst.mem_wd", 64'(mem_wd), 64'd0);
    chk("rst.state", 64'(dbg_state), 64'(IDLE));

    // contention from reset release: grants 0,1,0,1
    @(posedge clk);
    #1;
    rst_n  = 1'b1;
    mon_en = 1'b1;
    apply(mk(1'b1, 1'b0, 1'b0, 32'h1, 32'h0), mk(1'b1, 1'b0, 1'b0, 32'h2, 32'h0));
    expect_gnt("cont0", 1'b1, 1'b0);
    step(mk(1'b1, 1'b0, 1'b0, 32'h1, 32'h0), mk(1'b1, 1'b0, 1'b0, 32'h2, 32'h0));
    expect_gnt("cont1", 1'b0, 1'b1);
    step(mk(1'b1, 1'b0, 1'b0, 32'h3, 32'h0), mk(1'b1, 1'b0, 1'b0, 32'h4, 32'h0));
    expect_gnt("cont2", 1'b1, 1'b0);
    step(mk(1'b1, 1'b0, 1'b0, 32'h3, 32'h0), mk(1'b1, 1'b0, 1'b0, 32'h4, 32'h0));
    expect_gnt("cont3", 1'b0, 1'b1);

    // solo read of 0x10
    step(mk(1'b1, 1'b0, 1'b0, 32'h10, 32'h0), none_p);
    expect_gnt("solo", 1'b1, 1'b0);
    step(none_p, none_p);
    #2;
    chk("solo.rvalid_0", 64'(rvalid_0), 64'd1);
    chk("solo.rdata_0", 64'(rdata_0), 64'hDEAD_BEEF);
    chk("solo.rvalid_1", 64'(rvalid_1), 64'd0);

    // lock burst by port 1 (pointer now favours port 1)
    step(mk(1'b1, 1'b0, 1'b0, 32'h30, 32'h0), mk(1'b1, 1'b1, 1'b1, 32'h40, 32'h1111_0001));
    expect_gnt("burst0", 1'b0, 1'b1);
    chk("burst0.mem_we", 64'(mem_we), 64'd1);
    step(mk(1'b1, 1'b0, 1'b0, 32'h30, 32'h0), mk(1'b1, 1'b1, 1'b1, 32'h41, 32'h1111_0002));
    expect_gnt("burst1", 1'b0, 1'b1);
    chk("burst1.mem_we", 64'(mem_we), 64'd1);
    step(mk(1'b1, 1'b0, 1'b0, 32'h30, 32'h0), mk(1'b1, 1'b0, 1'b1, 32'h42, 32'h1111_0003));
    expect_gnt("burst2", 1'b0, 1'b1);
    chk("burst2.mem_we", 64'(mem_we), 64'd1);
    step(mk(1'b1, 1'b0, 1'b0, 32'h30, 32'h0), none_p);
    expect_gnt("burst3", 1'b1, 1'b0);

    // lock abandonment by port 0
    step(mk(1'b1, 1'b1, 1'b1, 32'h50, 32'h2222_0000), none_p);
    expect_gnt("aband0", 1'b1, 1'b0);
    step(none_p, mk(1'b1, 1'b0, 1'b0, 32'h60, 32'h0));
    expect_gnt("aband1", 1'b0, 1'b0);
    chk("aband1.state", 64'(dbg_state), 64'(OWN0));
    step(none_p, mk(1'b1, 1'b0, 1'b0, 32'h60, 32'h0));
    expect_gnt("aband2", 1'b0, 1'b1);
    chk("aband2.state", 64'(dbg_state), 64'(IDLE));

    // idle hold after a write to 0x20
    step(mk(1'b1, 1'b0, 1'b1, 32'h20, 32'h1234_5678), none_p);
    expect_gnt("hold_wr", 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      step(none_p, none_p);
      #2;
      chk("hold.mem_we", 64'(mem_we), 64'd0);
      chk("hold.mem_a", 64'(mem_a), 64'h20);
      chk("hold.mem_wd", 64'(mem_wd), 64'h1234_5678);
    end

    // random traffic against the model
    for (int i = 0; i < 400; i++) begin
      p0r = mk($urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0, 1'($urandom_range(0, 1)),
               ($urandom & 32'hFFFF_FF00) | 32'($urandom_range(0, 15)), $urandom);
      p1r = mk($urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0, 1'($urandom_range(0, 1)),
               ($urandom & 32'hFFFF_FF00) | 32'($urandom_range(0, 15)), $urandom);
      step(p0r, p1r);
    end
    step(none_p, none_p);

    // reset one cycle after a read grant drops the read
    step(mk(1'b1, 1'b0, 1'b0, 32'h10, 32'h0), none_p);
    expect_gnt("rstrd", 1'b1, 1'b0);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    apply(mk(1'b1, 1'b0, 1'b0, 32'h7, 32'h0), mk(1'b1, 1'b0, 1'b0, 32'h9, 32'h0));
    exp_r_q.delete();
    owner = -1;
    prio  = 0;
    #2;
    chk("rstrd.rvalid_0", 64'(rvalid_0), 64'd0);
    chk("rstrd.rdata_0", 64'(rdata_0), 64'd0);
    chk("rstrd.gnt_0", 64'(gnt_0), 64'd0);
    chk("rstrd.gnt_1", 64'(gnt_1), 64'd0);
    chk("rstrd.mem_we", 64'(mem_we), 64'd0);
    chk("rstrd.mem_a", 64'(mem_a), 64'd0);
    chk("rstrd.mem_wd", 64'(mem_wd), 64'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    apply(mk(1'b1, 1'b0, 1'b0, 32'h5, 32'h0), mk(1'b1, 1'b0, 1'b0, 32'h6, 32'h0));
    expect_gnt("rel0", 1'b1, 1'b0);
    step(mk(1'b1, 1'b0, 1'b0, 32'h5, 32'h0), mk(1'b1, 1'b0, 1'b0, 32'h6, 32'h0));
    expect_gnt("rel1", 1'b0, 1'b1);

    // drain and report
    repeat (3) step(none_p, none_p);
    #2;
    chk("drain.gnt_q", 64'(exp_g_q.size()), 64'd0);
    chk("drain.rd_q", 64'(exp_r_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
